receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per bit (115200 bps from 100 MHz).
REQ-002 SHALL have parameter HALF_BIT, default CLKS_PER_BIT/2 (434), start-bit mid-point offset.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd  input  1  one-cycle read strobe; consumes held byte.
REQ-007 SHALL have port data_out  output  8  last correctly framed byte.
REQ-008 SHALL have port data_valid  output  1  level; high while an unread byte is held.
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky; unread byte overwritten.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit counter cnt and a 3-bit index bit_idx.
REQ-014 IDLE: rx_s==0 -> START, cnt<=0.
REQ-015 START: at cnt==HALF_BIT-1, rx_s==0 -> DATA (cnt<=0, bit_idx<=0); rx_s==1 -> IDLE (glitch rejected, no output change).
REQ-016 DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into byte position bit_idx, cnt<=0; after bit_idx==7 -> STOP.
REQ-017 STOP: at cnt==CLKS_PER_BIT-1, rx_s==1 -> load data_out, set data_valid, -> IDLE.
REQ-018 STOP: rx_s==0 -> pulse frame_err for exactly one cycle, data_out/data_valid unchanged, -> BREAK.
REQ-019 BREAK: remain until rx_s==1, then -> IDLE; a held-low line SHALL NOT re-trigger reception.
REQ-020 Latency: data_valid SHALL rise HALF_BIT+9*CLKS_PER_BIT (8246) cycles, +/-1, after the first cycle with rx_s low.
REQ-021 rd with data_valid=1 SHALL clear data_valid and overrun next cycle; rd with data_valid=0 SHALL be ignored.
REQ-022 Good frame while data_valid=1 and rd=0 SHALL overwrite data_out, keep data_valid=1, set overrun.
REQ-023 Good frame in the same cycle as rd SHALL leave data_valid=1 with the new byte and SHALL NOT set overrun.
REQ-024 cnt SHALL be wide enough for CLKS_PER_BIT-1 (10 bits at default) and SHALL never wrap mid-bit.

Reset
REQ-025 rst SHALL force: state IDLE, cnt 0, bit_idx 0, synchronizer flops 1, data_out 0x00, data_valid 0, busy 0, frame_err 0, overrun 0.
REQ-026 rst mid-frame SHALL abandon the frame with no data_valid, frame_err, or overrun effect.

Structure
REQ-027 SHALL place CLKS_PER_BIT default and the state encoding in the shared UART package used by transmitter and receiver.
REQ-028 SHALL instantiate the 2-flop synchronizer as sub-module sync_2ff; the rest is a single module.

Verification
REQ-029 Send 0xA5, 8N1 at 868 clk/bit -> data_out=0xA5, data_valid high 8246+/-3 cycles after rx falls, frame_err=0.
REQ-030 rx low pulse of 200 cycles, then high -> START aborts at cnt 433, busy returns to 0, no data_valid.
REQ-031 Send 0x3C with stop bit 0, line held low 3000 cycles -> one frame_err pulse, busy stays 1 until rx high, no second frame.
REQ-032 Send 0x11 then 0x22 with no rd -> data_out=0x22, data_valid=1, overrun=1; rd -> both clear next cycle.
REQ-033 Assert rd in the exact cycle 0x55 completes, with 0x44 held -> data_out=0x55, data_valid=1, overrun=0.
REQ-034 Assert rst at bit 4 of 0xFF, then send 0x0F -> only 0x0F reported, all outputs at reset values during rst.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// default bit period, receiver FSM encoding and counter sizing.
package receiver_pkg;

    localparam int UART_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Smallest counter width that can hold clks_per_bit-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/receiver_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// line's idle level so a reset never looks like a start bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver: samples mid-bit, holds the last good byte until read,
// flags bad stop bits and overwritten unread bytes.
module receiver
    import receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    logic             rx_s;
    logic [2:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [2:0]       bit_idx_d, bit_idx_q;
    logic [7:0]       shift_d, shift_q;
    logic [7:0]       data_d, data_q;
    logic             valid_d, valid_q;
    logic             overrun_d, overrun_q;
    logic             frame_err_d, frame_err_q;
    logic             frame_good;
    logic             rd_take;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        frame_good  = 1'b0;
        rd_take     = rd && valid_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        frame_good = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A held-low line must go high before another start bit counts.
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A read landing together with a new byte counts as consuming the old one.
        if (frame_good) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (rd_take) begin
                overrun_d = 1'b0;
            end else if (valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (rd_take) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the UART receiver: a frame-level model predicts
// the output registers every cycle, directed scenarios pin specific values.
module tb_receiver;

    localparam int CPB  = 868;
    localparam int HALF = 434;
    // Two synchronizer stages plus the idle-detect cycle precede the
    // mid-start-bit wait and nine full bit periods.
    localparam int DONE_AFTER_FALL = 3 + HALF + 9 * CPB;

    typedef struct {
        int         when;
        logic [7:0] value;
        bit         stop_ok;
    } frame_ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ferr_seen = 0;

    frame_ev_t  pending[$];
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;

    receiver #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame-level model: a frame resolves a fixed time after its start bit falls.
    always @(posedge clk) begin
        frame_ev_t ev;
        cyc++;
        if (rst) begin
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            pending.delete();
        end else begin
            m_ferr = 1'b0;
            if (pending.size() > 0 && pending[0].when == cyc) begin
                ev = pending.pop_front();
                if (ev.stop_ok) begin
                    if (m_valid) begin
                        m_ovr = rd ? 1'b0 : 1'b1;
                    end
                    m_data  = ev.value;
                    m_valid = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end else if (rd && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("model_data_out", data_out, m_data);
            checkOutput("model_data_valid", {7'd0, data_valid}, {7'd0, m_valid});
            checkOutput("model_overrun", {7'd0, overrun}, {7'd0, m_ovr});
            checkOutput("model_frame_err", {7'd0, frame_err}, {7'd0, m_ferr});
            if (frame_err === 1'b1) begin
                ferr_seen++;
            end
        end
    end

    // Caller must be just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
        frame_ev_t ev;
        ev.when    = cyc + DONE_AFTER_FALL;
        ev.value   = value;
        ev.stop_ok = stop_bit;
        pending.push_back(ev);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = value[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic pulseRd();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic measureLatency(output int lat);
        lat = -1;
        for (int i = 1; i <= 9000; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int ferr_before;

        rst = 1'b1;
        rx  = 1'b1;
        rd  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data_out", data_out, 8'h00);
        checkOutput("reset_data_valid", {7'd0, data_valid}, 8'h00);
        checkOutput("reset_busy", {7'd0, busy}, 8'h00);
        checkOutput("reset_frame_err", {7'd0, frame_err}, 8'h00);
        checkOutput("reset_overrun", {7'd0, overrun}, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] good frame 0xA5");
        ferr_before = ferr_seen;
        fork
            applyStimulus(8'hA5, 1'b1);
            measureLatency(lat);
        join
        checkOutput("a5_latency_in_window", {7'd0, (lat >= 8243 && lat <= 8249)}, 8'h01);
        checkOutput("a5_data_out", data_out, 8'hA5);
        checkOutput("a5_data_valid", {7'd0, data_valid}, 8'h01);
        checkOutput("a5_no_frame_err", ferr_seen[7:0], ferr_before[7:0]);
        pulseRd();
        checkOutput("a5_read_clears_valid", {7'd0, data_valid}, 8'h00);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] 200-cycle glitch on rx");
        rx = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("glitch_busy_in_start", {7'd0, busy}, 8'h01);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("glitch_busy_released", {7'd0, busy}, 8'h00);
        checkOutput("glitch_no_valid", {7'd0, data_valid}, 8'h00);

        $display("[TB] 0x3C with bad stop bit and held-low line");
        ferr_before = ferr_seen;
        applyStimulus(8'h3C, 1'b0);
        repeat (3000) @(posedge clk);
        #1;
        checkOutput("break_busy_held", {7'd0, busy}, 8'h01);
        checkOutput("break_one_frame_err", ferr_seen[7:0], 8'(ferr_before + 1));
        checkOutput("break_no_valid", {7'd0, data_valid}, 8'h00);
        checkOutput("break_data_kept", data_out, 8'hA5);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("break_released", {7'd0, busy}, 8'h00);

        $display("[TB] 0x11 then 0x22 without reading");
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkOutput("overrun_data_out", data_out, 8'h22);
        checkOutput("overrun_data_valid", {7'd0, data_valid}, 8'h01);
        checkOutput("overrun_flag", {7'd0, overrun}, 8'h01);
        pulseRd();
        checkOutput("overrun_read_valid", {7'd0, data_valid}, 8'h00);
        checkOutput("overrun_read_flag", {7'd0, overrun}, 8'h00);

        $display("[TB] 0x44 held, read coincides with 0x55 completion");
        applyStimulus(8'h44, 1'b1);
        checkOutput("held_44_data", data_out, 8'h44);
        fork
            applyStimulus(8'h55, 1'b1);
            begin
                repeat (DONE_AFTER_FALL - 1) @(posedge clk);
                #1;
                pulseRd();
            end
        join
        checkOutput("same_cycle_data_out", data_out, 8'h55);
        checkOutput("same_cycle_valid", {7'd0, data_valid}, 8'h01);
        checkOutput("same_cycle_no_overrun", {7'd0, overrun}, 8'h00);

        $display("[TB] reset during bit 4 of 0xFF, then 0x0F");
        ferr_before = ferr_seen;
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                repeat (5 * CPB + HALF) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                checkOutput("midframe_rst_data_out", data_out, 8'h00);
                checkOutput("midframe_rst_valid", {7'd0, data_valid}, 8'h00);
                checkOutput("midframe_rst_busy", {7'd0, busy}, 8'h00);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        checkOutput("after_rst_no_valid", {7'd0, data_valid}, 8'h00);
        applyStimulus(8'h0F, 1'b1);
        checkOutput("after_rst_data_out", data_out, 8'h0F);
        checkOutput("after_rst_valid", {7'd0, data_valid}, 8'h01);
        checkOutput("after_rst_no_overrun", {7'd0, overrun}, 8'h00);
        checkOutput("after_rst_no_frame_err", ferr_seen[7:0], ferr_before[7:0]);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
